// File: rtl/uart_rx_fifo_ctrl.sv
// uart_rx_fifo_ctrl
//   APB-side controller for the UART receive path. Buffers received bytes in a
//   DEPTH-entry FIFO, exposes DATA (pop-on-read), STATUS (count/empty/full plus
//   sticky OVR/FERR/UDR, write-1-to-clear) and CTRL (RX_EN, IRQ_EN, THR, FLUSH),
//   and drives a registered level interrupt.
// Ports:
//   iCLK, iRESETn            clock, async active-low reset
//   iPSEL..iPWDATA, oPRDATA  APB slave, zero wait states (oPREADY tied 1)
//   iRX_DATA/VALID/FERR      byte stream from the RX datapath
//   oRX_EN                   enable to the RX datapath (CTRL[0])
//   oIRQ                     level interrupt, active high
module uart_rx_fifo_ctrl #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              iCLK,
    input  logic              iRESETn,
    input  logic              iPSEL,
    input  logic              iPENABLE,
    input  logic              iPWRITE,
    input  logic [ADDR_W-1:0] iPADDR,
    input  logic [31:0]       iPWDATA,
    output logic [31:0]       oPRDATA,
    output logic              oPREADY,
    input  logic [7:0]        iRX_DATA,
    input  logic              iRX_VALID,
    input  logic              iRX_FERR,
    output logic              oRX_EN,
    output logic              oIRQ
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] A_DATA = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(8);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d, ferr_q, ferr_d, udr_q, udr_d;
    logic             rx_en_q, rx_en_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic [2:0]       thr_q, thr_d;

    logic rd_acc, wr_acc, empty, full, data_rd, stat_wr, ctrl_wr;
    logic pop, push, flush, rx_take, ovr_set, ferr_set, udr_set;

    // Upper write-data bits have no register behind them.
    logic unused_pwdata;
    assign unused_pwdata = ^iPWDATA[31:9];

    always_comb begin
        rd_acc  = iPSEL & iPENABLE & ~iPWRITE;
        wr_acc  = iPSEL & iPENABLE & iPWRITE;
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_W'(DEPTH));
        data_rd = rd_acc & (iPADDR == A_DATA);
        stat_wr = wr_acc & (iPADDR == A_STAT);
        ctrl_wr = wr_acc & (iPADDR == A_CTRL);
        pop     = data_rd & ~empty;
        udr_set = data_rd & empty;
        flush   = ctrl_wr & iPWDATA[5];
        rx_take = iRX_VALID & rx_en_q;
        // A same-cycle pop frees a slot, so a full FIFO still accepts the byte.
        push     = rx_take & (~full | pop) & ~flush;
        ovr_set  = rx_take & full & ~pop;
        ferr_set = rx_take & iRX_FERR;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = iRX_DATA;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        // Set events take priority over a coincident write-1-to-clear.
        ovr_d    = ovr_set  | (ovr_q  & ~(stat_wr & iPWDATA[6]));
        ferr_d   = ferr_set | (ferr_q & ~(stat_wr & iPWDATA[7]));
        udr_d    = udr_set  | (udr_q  & ~(stat_wr & iPWDATA[8]));
        rx_en_d  = ctrl_wr ? iPWDATA[0]   : rx_en_q;
        irq_en_d = ctrl_wr ? iPWDATA[1]   : irq_en_q;
        thr_d    = ctrl_wr ? iPWDATA[4:2] : thr_q;
        irq_d    = irq_en_q & ((cnt_q >= (CNT_W'(thr_q) + CNT_W'(1))) | ovr_q | ferr_q);
    end

    always_comb begin
        oPRDATA = '0;
        if (rd_acc) begin
            case (iPADDR)
                A_DATA:  if (!empty) oPRDATA[7:0] = mem_q[rd_ptr_q];
                A_STAT:  oPRDATA[8:0] = {udr_q, ferr_q, ovr_q, full, empty, 4'(cnt_q)};
                A_CTRL:  oPRDATA[4:0] = {thr_q, irq_en_q, rx_en_q};
                default: oPRDATA = '0;
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
            udr_q    <= 1'b0;
            rx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            thr_q    <= '0;
            irq_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
            udr_q    <= udr_d;
            rx_en_q  <= rx_en_d;
            irq_en_q <= irq_en_d;
            thr_q    <= thr_d;
            irq_q    <= irq_d;
        end
    end

    assign oPREADY = 1'b1;
    assign oRX_EN  = rx_en_q;
    assign oIRQ    = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed plus randomized bench for uart_rx_fifo_ctrl. A queue-based model of
// the register view predicts every read value and the interrupt level.
module tb_uart_rx_fifo_ctrl;
    logic        iCLK = 1'b0, iRESETn = 1'b0;
    logic        iPSEL = 0, iPENABLE = 0, iPWRITE = 0;
    logic [3:0]  iPADDR = '0;
    logic [31:0] iPWDATA = '0;
    logic [31:0] oPRDATA;
    logic        oPREADY, oRX_EN, oIRQ;
    logic [7:0]  iRX_DATA = '0;
    logic        iRX_VALID = 0, iRX_FERR = 0;

    uart_rx_fifo_ctrl #(.DEPTH(8), .ADDR_W(4)) dut (
        .iCLK(iCLK), .iRESETn(iRESETn), .iPSEL(iPSEL), .iPENABLE(iPENABLE),
        .iPWRITE(iPWRITE), .iPADDR(iPADDR), .iPWDATA(iPWDATA), .oPRDATA(oPRDATA),
        .oPREADY(oPREADY), .iRX_DATA(iRX_DATA), .iRX_VALID(iRX_VALID),
        .iRX_FERR(iRX_FERR), .oRX_EN(oRX_EN), .oIRQ(oIRQ));

    always #5 iCLK = ~iCLK;

    int total = 0, bad = 0;

    // Reference model: software-visible state only.
    logic [7:0] q[$];
    bit m_ovr, m_ferr, m_udr, m_rx_en, m_irq_en;
    int m_thr;

    task automatic m_reset();
        q.delete();
        m_ovr = 0; m_ferr = 0; m_udr = 0; m_rx_en = 0; m_irq_en = 0; m_thr = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [3:0] a);
        logic [31:0] v = 0;
        case (a)
            4'h0: if (q.size() > 0) v = {24'h0, q[0]};
            4'h4: v = (m_udr ? 32'h100 : 0) | (m_ferr ? 32'h80 : 0) | (m_ovr ? 32'h40 : 0)
                    | (q.size() == 8 ? 32'h20 : 0) | (q.size() == 0 ? 32'h10 : 0) | q.size();
            4'h8: v = (m_thr << 2) | (m_irq_en ? 2 : 0) | (m_rx_en ? 1 : 0);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit m_irq();
        return m_irq_en && (q.size() >= m_thr + 1 || m_ovr || m_ferr);
    endfunction

    task automatic m_step(input bit sel, input bit wr, input logic [3:0] a, input logic [31:0] wd,
                          input bit rxv, input logic [7:0] rxd, input bit rxf);
        bit pop = 0, flush = 0, full, take;
        full = (q.size() == 8);
        take = rxv && m_rx_en;
        if (sel && !wr && a == 4'h0) begin
            if (q.size() > 0) pop = 1; else m_udr = 1;
        end
        if (sel && wr && a == 4'h8 && wd[5]) flush = 1;
        if (sel && wr && a == 4'h4) begin
            if (wd[6]) m_ovr = 0;
            if (wd[7]) m_ferr = 0;
            if (wd[8]) m_udr = 0;
        end
        if (sel && !wr && a == 4'h0 && !pop) m_udr = 1;
        if (take && full && !pop) m_ovr = 1;
        if (take && rxf) m_ferr = 1;
        if (pop) void'(q.pop_front());
        if (take && (!full || pop)) q.push_back(rxd);
        if (flush) q.delete();
        if (sel && wr && a == 4'h8) begin
            m_rx_en = wd[0]; m_irq_en = wd[1]; m_thr = int'(wd[4:2]);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One APB access (setup + access) and/or one RX pulse aligned with the access
    // phase. Starts and ends at a falling edge.
    task automatic xfer(input bit sel, input bit wr, input logic [3:0] a, input logic [31:0] wd,
                        input bit rxv, input logic [7:0] rxd, input bit rxf,
                        input string tag, output logic [31:0] rd);
        logic [31:0] exp;
        if (sel) begin
            iPSEL = 1; iPWRITE = wr; iPADDR = a; iPWDATA = wd; iPENABLE = 0;
            @(posedge iCLK); @(negedge iCLK);
            iPENABLE = 1;
        end
        iRX_VALID = rxv; iRX_DATA = rxd; iRX_FERR = rxf;
        #1;
        rd  = oPRDATA;
        exp = m_read(a);
        if (sel && !wr) chk(tag, rd, exp);
        @(posedge iCLK);
        m_step(sel, wr, a, wd, rxv, rxd, rxf);
        @(negedge iCLK);
        iPSEL = 0; iPENABLE = 0; iPWRITE = 0; iRX_VALID = 0; iRX_FERR = 0;
    endtask

    logic [31:0] rd;

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] wd);
        xfer(1, 1, a, wd, 0, 8'h0, 0, "wr", rd);
    endtask
    task automatic rd_reg(input logic [3:0] a, input string tag);
        xfer(1, 0, a, 32'h0, 0, 8'h0, 0, tag, rd);
    endtask
    task automatic push(input logic [7:0] d, input bit f);
        xfer(0, 0, 4'h0, 32'h0, 1, d, f, "push", rd);
    endtask
    task automatic chk_irq(input string tag);
        @(posedge iCLK); @(negedge iCLK);
        chk(tag, 32'(oIRQ), 32'(m_irq()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        repeat (2) @(negedge iCLK);
        chk("rst_prdata", oPRDATA, 32'h0);
        chk("rst_pready", 32'(oPREADY), 32'h1);
        chk("rst_rx_en", 32'(oRX_EN), 32'h0);
        chk("rst_irq", 32'(oIRQ), 32'h0);
        iRESETn = 1;
        @(negedge iCLK);
        rd_reg(4'h4, "rst_status");
        chk("rst_status_const", rd, 32'h10);
        rd_reg(4'h8, "rst_ctrl");

        // Basic push/pop.
        wr_reg(4'h8, 32'h03);
        chk("rx_en_on", 32'(oRX_EN), 32'h1);
        push(8'h55, 0); push(8'hAA, 0);
        rd_reg(4'h4, "st_two");
        chk("st_two_const", rd, 32'h2);
        rd_reg(4'h0, "rd_55"); chk("rd_55_const", rd, 32'h55);
        rd_reg(4'h0, "rd_aa"); chk("rd_aa_const", rd, 32'hAA);
        rd_reg(4'h4, "st_empty");

        // Overflow.
        for (int i = 1; i <= 9; i++) push(8'(i), 0);
        rd_reg(4'h4, "st_ovr"); chk("st_ovr_const", rd, 32'h68);
        chk_irq("irq_ovr");
        for (int i = 1; i <= 8; i++) rd_reg(4'h0, "rd_ovr_data");
        wr_reg(4'h4, 32'h40);
        rd_reg(4'h4, "st_ovr_clr"); chk("st_ovr_clr_const", rd, 32'h10);
        chk_irq("irq_ovr_clr");

        // Threshold: level 4.
        wr_reg(4'h8, 32'h0F);
        for (int i = 0; i < 3; i++) push(8'($urandom), 0);
        chk_irq("irq_thr_below");
        push(8'($urandom), 0);
        chk_irq("irq_thr_at"); chk("irq_thr_at_const", 32'(oIRQ), 32'h1);
        rd_reg(4'h0, "rd_thr");
        chk_irq("irq_thr_drop"); chk("irq_thr_drop_const", 32'(oIRQ), 32'h0);
        for (int i = 0; i < 3; i++) rd_reg(4'h0, "rd_thr_drain");

        // Framing error and underflow.
        push(8'h7E, 1);
        rd_reg(4'h4, "st_ferr");
        chk_irq("irq_ferr");
        rd_reg(4'h0, "rd_7e"); chk("rd_7e_const", rd, 32'h7E);
        rd_reg(4'h0, "rd_udr"); chk("rd_udr_const", rd, 32'h0);
        rd_reg(4'h4, "st_udr"); chk("st_udr_const", rd, 32'h190);
        wr_reg(4'h4, 32'h180);
        rd_reg(4'h4, "st_w1c"); chk("st_w1c_const", rd, 32'h10);

        // Full FIFO with simultaneous pop and push.
        for (int i = 0; i < 8; i++) push(8'($urandom), 0);
        xfer(1, 0, 4'h0, 32'h0, 1, 8'h33, 0, "rd_full_push", rd);
        rd_reg(4'h4, "st_full_push"); chk("st_full_push_const", rd, 32'h28);
        for (int i = 0; i < 8; i++) rd_reg(4'h0, "rd_wrap");
        chk("rd_wrap_last", rd, 32'h33);

        // W1C coinciding with a new overflow: set wins.
        for (int i = 0; i < 8; i++) push(8'($urandom), 0);
        xfer(1, 1, 4'h4, 32'h40, 1, 8'h99, 0, "w1c_vs_set", rd);
        rd_reg(4'h4, "st_set_wins"); chk("st_set_wins_const", rd, 32'h68);
        wr_reg(4'h4, 32'h1C0);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            int r = $urandom_range(0, 10);
            case (r)
                0, 1, 2, 3: push(8'($urandom), $urandom_range(0, 7) == 0);
                4, 5: xfer(1, 0, 4'h0, 0, $urandom_range(0, 1) == 1, 8'($urandom), 0, "rnd_data", rd);
                6: rd_reg(4'h4, "rnd_status");
                7: xfer(1, 1, 4'h4, {23'h0, 3'($urandom), 6'h0}, $urandom_range(0, 1) == 1,
                        8'($urandom), $urandom_range(0, 3) == 0, "rnd_w1c", rd);
                8: wr_reg(4'h8, {26'h0, $urandom_range(0, 5) == 0, 3'($urandom),
                                 1'($urandom), $urandom_range(0, 4) != 0});
                9: rd_reg(4'h8, "rnd_ctrl");
                default: rd_reg(4'($urandom_range(3, 7) * 4 - 4 * ($urandom_range(0, 1))), "rnd_addr");
            endcase
            chk_irq("rnd_irq");
        end

        // RX disabled: pulses ignored.
        wr_reg(4'h8, 32'h20);
        wr_reg(4'h4, 32'h1C0);
        for (int i = 0; i < 3; i++) push(8'($urandom), 1);
        rd_reg(4'h4, "st_rx_off"); chk("st_rx_off_const", rd, 32'h10);

        // Flush with 5 entries keeps OVR.
        wr_reg(4'h8, 32'h01);
        for (int i = 0; i < 9; i++) push(8'($urandom), 0);
        for (int i = 0; i < 3; i++) rd_reg(4'h0, "rd_pre_flush");
        wr_reg(4'h8, 32'h21);
        rd_reg(4'h4, "st_flush"); chk("st_flush_const", rd, 32'h50);
        rd_reg(4'h8, "ctrl_flush_rd0");

        // Asynchronous reset mid-sequence.
        wr_reg(4'h8, 32'h03);
        push(8'h11, 1); push(8'h22, 0);
        chk_irq("irq_pre_rst");
        iPSEL = 1; iPADDR = 4'h4;
        #2 iRESETn = 0;
        #1;
        m_reset();
        chk("mid_rst_rx_en", 32'(oRX_EN), 32'h0);
        chk("mid_rst_irq", 32'(oIRQ), 32'h0);
        chk("mid_rst_prdata", oPRDATA, 32'h0);
        chk("mid_rst_pready", 32'(oPREADY), 32'h1);
        iPSEL = 0;
        @(negedge iCLK);
        iRESETn = 1;
        @(negedge iCLK);
        rd_reg(4'h4, "post_rst_status"); chk("post_rst_status_const", rd, 32'h10);
        rd_reg(4'h0, "post_rst_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
